// File: rtl/dac_tx_pkg.sv
// Shared definitions for the DAC transmit path: FSM state encodings and default widths.
package dac_tx_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam int DW_DEF        = 8;
    localparam int FIFO_AW_DEF   = 4;
    localparam int DIV_W_DEF     = 16;
    localparam int PRIME_LVL_DEF = 8;

endpackage

// File: rtl/dac_tx_sync_fifo.sv
// Single-clock FIFO with synchronous flush; read data is the combinational head word.
module dac_tx_sync_fifo
    import dac_tx_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int FIFO_AW = FIFO_AW_DEF
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [DW-1:0]      wdata,
    output logic [DW-1:0]      rdata,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               empty
);

    localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW + 1)'(2 ** FIFO_AW);

    logic [DW-1:0]      mem [2 ** FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (level == DEPTH);
    assign empty = (level == '0);

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge wb_clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dac_tx.sv
// DAC transmit block: buffers DSP samples and replays them at divider+1 cycles per sample.
// Optional DAC_UNDERRUN_CNT_EN adds a saturating underrun event counter port.
module dac_tx
    import dac_tx_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int FIFO_AW   = FIFO_AW_DEF,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int PRIME_LVL = PRIME_LVL_DEF
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic               enable,
    input  logic [DIV_W-1:0]   divider,
    input  logic [DW-1:0]      din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [DW-1:0]      dac_data,
    output logic               dac_strobe,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underrun,
    input  logic               underrun_clr,
`ifdef DAC_UNDERRUN_CNT_EN
    output logic [15:0]        underrun_count,
`endif
    output logic [1:0]         fsm_state
);

    localparam logic [FIFO_AW:0] PRIME_LEVEL = (FIFO_AW + 1)'(PRIME_LVL);

    logic [1:0]       state;
    logic [DIV_W-1:0] cnt;
    logic [DW-1:0]    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             tick;
    logic             underrun_evt;

    // A word transfers on any cycle where din_valid and din_ready are both high;
    // din_ready never depends on din_valid, so the producer may hold valid freely.
    assign din_ready    = enable && (state != IDLE) && !fifo_full;
    assign push         = din_valid && din_ready;
    assign tick         = enable && (state == RUN) && (cnt == divider);
    assign pop          = tick && !fifo_empty;
    assign underrun_evt = tick && fifo_empty;
    assign fsm_state    = state;

    dac_tx_sync_fifo #(
        .DW      (DW),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .push   (push),
        .pop    (pop),
        .flush  (!enable),
        .wdata  (din),
        .rdata  (head),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dac_data   <= '0;
            dac_strobe <= 1'b0;
        end else begin
            dac_strobe <= pop;
            if (!enable) begin
                state    <= IDLE;
                cnt      <= '0;
                dac_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                        cnt   <= '0;
                    end
                    PRIME: begin
                        cnt <= '0;
                        if (fifo_level >= PRIME_LEVEL) state <= RUN;
                    end
                    RUN: begin
                        if (tick) begin
                            cnt <= '0;
                            // An empty FIFO on a tick keeps the last sample and re-primes.
                            if (pop) dac_data <= head;
                            else     state    <= PRIME;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)            underrun <= 1'b0;
        else if (underrun_evt) underrun <= 1'b1;
        else if (underrun_clr) underrun <= 1'b0;
    end

`ifdef DAC_UNDERRUN_CNT_EN
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            underrun_count <= '0;
        end else if (underrun_evt) begin
            if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 1'b1;
        end else if (underrun_clr) begin
            underrun_count <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_dac_tx.sv
// Bench for dac_tx: accepted words are queued as expected DAC output; a negedge monitor checks each strobe.
module tb_dac_tx;
    import dac_tx_pkg::*;

    localparam int DW        = 8;
    localparam int FIFO_AW   = 4;
    localparam int DIV_W     = 16;
    localparam int PRIME_LVL = 8;

    logic               wb_clk;
    logic               wb_rst;
    logic               enable;
    logic [DIV_W-1:0]   divider;
    logic [DW-1:0]      din;
    logic               din_valid;
    logic               din_ready;
    logic [DW-1:0]      dac_data;
    logic               dac_strobe;
    logic [FIFO_AW:0]   fifo_level;
    logic               underrun;
    logic               underrun_clr;
    logic [1:0]         fsm_state;
`ifdef DAC_UNDERRUN_CNT_EN
    logic [15:0]        underrun_count;
    logic [15:0]        count_before;
`endif

    logic [DW-1:0] exp_q[$];
    int            strobe_t[$];
    int            cyc;
    int            checks;
    int            errors;
    int            strobe_cnt;
    logic [DW-1:0] mon_exp;

    dac_tx #(
        .DW        (DW),
        .FIFO_AW   (FIFO_AW),
        .DIV_W     (DIV_W),
        .PRIME_LVL (PRIME_LVL)
    ) dut (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .enable         (enable),
        .divider        (divider),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .dac_data       (dac_data),
        .dac_strobe     (dac_strobe),
        .fifo_level     (fifo_level),
        .underrun       (underrun),
        .underrun_clr   (underrun_clr),
`ifdef DAC_UNDERRUN_CNT_EN
        .underrun_count (underrun_count),
`endif
        .fsm_state      (fsm_state)
    );

    // Clock and cycle counter
    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must present the oldest word still owed to the DAC
    always @(negedge wb_clk) begin
        if (!wb_rst && dac_strobe) begin
            strobe_cnt++;
            strobe_t.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_unexpected: dac_data=0x%0h with nothing pending", dac_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("dac_data_order", 32'(dac_data), 32'(mon_exp));
            end
        end
    end

    task automatic push_word(input logic [DW-1:0] d, input int budget, output int acc_cyc);
        int  n = 0;
        bit  done = 0;
        din       = d;
        din_valid = 1'b1;
        acc_cyc   = -1;
        while (!done && n < budget) begin
            @(negedge wb_clk);
            if (din_ready) begin
                exp_q.push_back(d);
                acc_cyc = cyc;
                done    = 1;
            end
            @(posedge wb_clk);
            #1;
            n++;
        end
        din_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: word 0x%0h not accepted in %0d cycles", d, budget);
        end
    endtask

    task automatic push_n(input int count, input int budget, output logic [DW-1:0] last, output int acc8);
        int acc;
        acc8 = -1;
        last = '0;
        for (int i = 1; i <= count; i++) begin
            last = DW'($urandom);
            push_word(last, budget, acc);
            if (i == PRIME_LVL) acc8 = acc;
        end
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(negedge wb_clk);
            #1;
            n++;
        end
        if (strobe_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout with %0d strobes, want %0d", name, strobe_cnt, target);
        end
    endtask

    task automatic wait_underrun(input int budget, input string name);
        int n = 0;
        while (underrun !== 1'b1 && n < budget) begin
            @(negedge wb_clk);
            #1;
            n++;
        end
        if (underrun !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: underrun not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic disable_dut();
        enable = 1'b0;
        @(posedge wb_clk);
        #1;
        exp_q.delete();
    endtask

    task automatic clear_underrun();
        underrun_clr = 1'b1;
        @(posedge wb_clk);
        #1;
        underrun_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int            s0;
        int            t0;
        int            acc;
        int            acc8;
        logic [DW-1:0] last;

        checks = 0; errors = 0; strobe_cnt = 0;
        wb_rst = 1'b1; enable = 1'b0; divider = '0; din = '0;
        din_valid = 1'b0; underrun_clr = 1'b0;
        repeat (3) @(posedge wb_clk);
        #1;

        check("reset_dac_data", 32'(dac_data), 0);
        check("reset_strobe", 32'(dac_strobe), 0);
        check("reset_underrun", 32'(underrun), 0);
        check("reset_level", 32'(fifo_level), 0);
        check("reset_din_ready", 32'(din_ready), 0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        @(negedge wb_clk);
        wb_rst = 1'b0;
        @(posedge wb_clk);
        #1;

        // Test 1: divider=3, words 0x01..0x10 at one strobe per 4 cycles
        divider = 16'd3;
        enable  = 1'b1;
        s0 = strobe_cnt;
        t0 = strobe_t.size();
        acc8 = -1;
        for (int i = 1; i <= 16; i++) begin
            push_word(DW'(i), 50, acc);
            if (i == PRIME_LVL) acc8 = acc;
        end
        wait_strobes(s0 + 16, 200, "t1_drain");
        check("t1_all_out", 32'(exp_q.size()), 0);
        if (strobe_t.size() >= t0 + 16) begin
            check("t1_first_strobe", 32'(strobe_t[t0]), 32'(acc8 + 3 + 3));
            for (int k = 1; k < 16; k++)
                check("t1_period", 32'(strobe_t[t0 + k] - strobe_t[t0 + k - 1]), 4);
        end
        wait_underrun(50, "t1_underrun");
        check("t1_underrun", 32'(underrun), 1);
        check("t1_state_prime", 32'(fsm_state), 32'(PRIME));
        check("t1_hold_data", 32'(dac_data), 32'h10);
        check("t1_strobe_count", 32'(strobe_cnt), 32'(s0 + 16));
        clear_underrun();
        check("t1_clr", 32'(underrun), 0);

        // Test 3: eight words at divider=0 -> back-to-back strobes, then underrun
        disable_dut();
        divider = 16'd0;
        enable  = 1'b1;
        s0 = strobe_cnt;
        t0 = strobe_t.size();
        push_n(8, 20, last, acc8);
        wait_strobes(s0 + 8, 100, "t3_drain");
        wait_underrun(20, "t3_underrun");
        check("t3_underrun", 32'(underrun), 1);
        check("t3_hold_data", 32'(dac_data), 32'(last));
        check("t3_state_prime", 32'(fsm_state), 32'(PRIME));
        check("t3_strobe_count", 32'(strobe_cnt), 32'(s0 + 8));
        if (strobe_t.size() >= t0 + 8) begin
            check("t3_first_strobe", 32'(strobe_t[t0]), 32'(acc8 + 3));
            for (int k = 1; k < 8; k++)
                check("t3_gap", 32'(strobe_t[t0 + k] - strobe_t[t0 + k - 1]), 1);
        end

        // Test 4: clear request coincides with a fresh underrun event
        clear_underrun();
        check("t4_pre_clr", 32'(underrun), 0);
`ifdef DAC_UNDERRUN_CNT_EN
        count_before = underrun_count;
`endif
        s0 = strobe_cnt;
        push_n(8, 20, last, acc8);
        wait_strobes(s0 + 8, 100, "t4_drain");
        underrun_clr = 1'b1;
        @(posedge wb_clk);
        #1;
        underrun_clr = 1'b0;
        check("t4_set_beats_clr", 32'(underrun), 1);
        check("t4_state_prime", 32'(fsm_state), 32'(PRIME));
`ifdef DAC_UNDERRUN_CNT_EN
        check("t4_count_inc", 32'(underrun_count), 32'(count_before + 16'd1));
`endif

        // Test 2: fill to 16 with no pops, extra words stall then all come out
        disable_dut();
        divider = 16'd60;
        enable  = 1'b1;
        s0 = strobe_cnt;
        for (int i = 1; i <= 16; i++) push_word(DW'(8'h40 + i), 20, acc);
        din       = DW'(8'h40 + 17);
        din_valid = 1'b1;
        repeat (4) begin
            @(negedge wb_clk);
            check("t2_stall_ready", 32'(din_ready), 0);
            check("t2_level_full", 32'(fifo_level), 16);
            @(posedge wb_clk);
            #1;
        end
        din_valid = 1'b0;
        for (int i = 17; i <= 20; i++) push_word(DW'(8'h40 + i), 200, acc);
        wait_strobes(s0 + 20, 1600, "t2_drain");
        check("t2_none_lost", 32'(exp_q.size()), 0);
        check("t2_strobe_count", 32'(strobe_cnt), 32'(s0 + 20));

        // Test 5: enable dropped mid-RUN with five words buffered
        disable_dut();
        divider = 16'd10;
        enable  = 1'b1;
        s0 = strobe_cnt;
        push_n(8, 20, last, acc8);
        wait_strobes(s0 + 3, 100, "t5_three");
        check("t5_level5", 32'(fifo_level), 5);
        enable = 1'b0;
        @(posedge wb_clk);
        #1;
        exp_q.delete();
        check("t5_level0", 32'(fifo_level), 0);
        check("t5_data0", 32'(dac_data), 0);
        check("t5_state_idle", 32'(fsm_state), 32'(IDLE));
        check("t5_ready0", 32'(din_ready), 0);
        s0 = strobe_cnt;
        repeat (40) @(posedge wb_clk);
        #1;
        check("t5_no_strobe", 32'(strobe_cnt), 32'(s0));
        check("t5_underrun_sticky", 32'(underrun), 1);

        // Test 6: asynchronous reset mid-RUN, then a clean re-prime
        divider = 16'd2;
        enable  = 1'b1;
        s0 = strobe_cnt;
        push_n(8, 20, last, acc8);
        wait_strobes(s0 + 2, 100, "t6_two");
        #2;
        wb_rst = 1'b1;
        #1;
        check("t6_rst_data", 32'(dac_data), 0);
        check("t6_rst_level", 32'(fifo_level), 0);
        check("t6_rst_underrun", 32'(underrun), 0);
        check("t6_rst_strobe", 32'(dac_strobe), 0);
        check("t6_rst_state", 32'(fsm_state), 32'(IDLE));
        @(posedge wb_clk);
        #1;
        exp_q.delete();
        @(negedge wb_clk);
        wb_rst = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 10; i++) push_word(DW'($urandom), 20, acc);
        wait_strobes(s0 + 10, 100, "t6_reprime");
        check("t6_all_out", 32'(exp_q.size()), 0);

        // Random rounds: arbitrary gaps and divider; order must hold and leftovers stay buffered
        for (int r = 0; r < 3; r++) begin
            disable_dut();
            clear_underrun();
            divider = DIV_W'($urandom_range(0, 5));
            enable  = 1'b1;
            for (int i = 0; i < 40; i++) begin
                push_word(DW'($urandom), 100, acc);
                repeat ($urandom_range(0, 3)) @(posedge wb_clk);
                #1;
            end
            repeat (200) @(posedge wb_clk);
            #1;
            check("rand_pending", 32'(fifo_level), 32'(exp_q.size()));
        end
        disable_dut();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
